// File: rtl/exp_seq_pkg.sv
// Shared constants, opcodes and FSM state type for the exp(x) Taylor-series sequencer.
package exp_seq_pkg;

  localparam logic [3:0]  OP_NOP  = 4'b0000;
  localparam logic [3:0]  OP_FMUL = 4'b0111;
  localparam logic [3:0]  OP_FADD = 4'b0101;
  localparam logic [31:0] FP_ONE  = 32'h3F800000;

  typedef enum logic [2:0] {
    StIdle,
    StMulX,
    StMulR,
    StAdd,
    StFin
  } state_e;

  // fp32 1/k for k = 1..7; entry 0 is never addressed
  localparam logic [7:0][31:0] RECIP = {
    32'h3E124925, 32'h3E2AAAAB, 32'h3E4CCCCD, 32'h3E800000,
    32'h3EAAAAAB, 32'h3F000000, 32'h3F800000, 32'h00000000
  };

endpackage

// File: rtl/exp_seq_recip_rom.sv
// Combinational lookup of the fp32 reciprocal 1/k used to form x^k/k!.
module exp_seq_recip_rom
  import exp_seq_pkg::*;
(
  input  logic [2:0]  k_i,
  output logic [31:0] recip_o
);

  assign recip_o = RECIP[k_i];

endmodule

// File: rtl/exp_taylor_seq.sv
// exp(x) as a truncated Taylor series, sequenced over one shared fp ALU via req/gnt.
module exp_taylor_seq
  import exp_seq_pkg::*;
#(
  parameter int unsigned N_TERMS = 6,
  parameter int unsigned ALU_LAT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] x_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        alu_req,
  input  logic        alu_gnt,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_op,
  input  logic [63:0] alu_out
);

  localparam int unsigned CntW = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      k_q, k_d;
  logic [31:0]     x_q, x_d, term_q, term_d, sum_q, sum_d, result_q, result_d;
  logic            busy_q, busy_d, done_q, done_d;
  logic [31:0]     recip;
  logic [31:0]     alu_res;
  logic [31:0]     unused_alu_hi;
  logic            fire;
  logic            last_k;

  exp_seq_recip_rom u_recip_rom (
    .k_i     (k_q),
    .recip_o (recip)
  );

  assign alu_res       = alu_out[31:0];
  assign unused_alu_hi = alu_out[63:32];
  // An op completes on the granted cycle that follows ALU_LAT earlier granted cycles
  assign fire   = alu_gnt && (cnt_q == CntW'(ALU_LAT));
  assign last_k = (k_q == 3'(N_TERMS - 1));

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    k_d      = k_q;
    x_d      = x_q;
    term_d   = term_q;
    sum_d    = sum_q;
    result_d = result_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    alu_req  = 1'b0;
    alu_op   = OP_NOP;
    alu_a    = '0;
    alu_b    = '0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          x_d     = x_in;
          term_d  = FP_ONE;
          sum_d   = FP_ONE;
          k_d     = 3'd1;
          busy_d  = 1'b1;
          state_d = StMulX;
        end
      end
      StMulX: begin
        alu_req = 1'b1;
        alu_op  = OP_FMUL;
        alu_a   = term_q;
        alu_b   = x_q;
        if (fire) begin
          term_d  = alu_res;
          state_d = StMulR;
        end
      end
      StMulR: begin
        alu_req = 1'b1;
        alu_op  = OP_FMUL;
        alu_a   = term_q;
        alu_b   = recip;
        if (fire) begin
          term_d  = alu_res;
          state_d = StAdd;
        end
      end
      StAdd: begin
        alu_req = 1'b1;
        alu_op  = OP_FADD;
        alu_a   = sum_q;
        alu_b   = term_q;
        if (fire) begin
          sum_d = alu_res;
          if (last_k) begin
            state_d = StFin;
          end else begin
            k_d     = k_q + 3'd1;
            state_d = StMulX;
          end
        end
      end
      StFin: begin
        result_d = sum_q;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (alu_req && alu_gnt) begin
      cnt_d = fire ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      k_q      <= 3'd1;
      x_q      <= '0;
      term_q   <= '0;
      sum_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      k_q      <= k_d;
      x_q      <= x_d;
      term_q   <= term_d;
      sum_q    <= sum_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

endmodule
